// File: rtl/serial_word_feeder_if.sv
// Handshake and serial-output bundle for serial_word_feeder.
// slave: the feeder itself. master: the word producer / serial consumer side.
interface serial_word_feeder_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             stall;
    logic             dout;
    logic             dout_valid;
    logic             word_start;
    logic             word_last;
    logic             busy;

    modport slave (
        input  load_data,
        input  load_valid,
        input  stall,
        output load_ready,
        output dout,
        output dout_valid,
        output word_start,
        output word_last,
        output busy
    );

    modport master (
        output load_data,
        output load_valid,
        output stall,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  word_start,
        input  word_last,
        input  busy
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-in, serial-out word feeder with a one-word holding register so
// back-to-back words leave the shifter without an idle cycle.
// Build option: define SERIAL_FEEDER_LSB_FIRST_EN to shift LSB first
// (default is MSB first). Timing and handshake are the same in both builds.
module serial_word_feeder #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_word_feeder_if.slave bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hr_q, hr_d;
    logic               hr_full_q, hr_full_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               word_start_q, word_start_d;

    logic               active;
    logic               accept;
    logic [WIDTH-1:0]   sr_shifted;
    logic               sr_next_bit;
    logic               hr_first_bit;

    assign active = (state_q == StShift);
    assign accept = bus.load_valid && !hr_full_q;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    assign sr_shifted   = sr_q >> 1;
    assign sr_next_bit  = sr_q[1];
    assign hr_first_bit = hr_q[0];
`else
    assign sr_shifted   = sr_q << 1;
    assign sr_next_bit  = sr_q[WIDTH-2];
    assign hr_first_bit = hr_q[WIDTH-1];
`endif

    // State register: asynchronous clear of everything, including held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hr_q         <= '0;
            hr_full_q    <= 1'b0;
            sr_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hr_q         <= hr_d;
            hr_full_q    <= hr_full_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_start_q <= word_start_d;
        end
    end

    // Next state: holding-register accept plus shift / reload / idle decision.
    always_comb begin
        state_d      = state_q;
        hr_d         = hr_q;
        hr_full_d    = hr_full_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        word_start_d = word_start_q;

        // Accept and reload never coincide: accept needs hr empty, reload needs it full.
        if (accept) begin
            hr_d      = bus.load_data;
            hr_full_d = 1'b1;
        end

        if (!bus.stall) begin
            if (active && (cnt_q != LastIdx)) begin
                cnt_d        = cnt_q + CNT_W'(1);
                sr_d         = sr_shifted;
                dout_d       = sr_next_bit;
                word_start_d = 1'b0;
            end else if (hr_full_q) begin
                sr_d         = hr_q;
                hr_full_d    = 1'b0;
                cnt_d        = '0;
                dout_d       = hr_first_bit;
                dout_valid_d = 1'b1;
                word_start_d = 1'b1;
                state_d      = StShift;
            end else begin
                state_d      = StIdle;
                dout_valid_d = 1'b0;
                dout_d       = 1'b0;
                word_start_d = 1'b0;
                cnt_d        = '0;
            end
        end
    end

    // Outputs: registered bits plus combinational flags derived from state only.
    always_comb begin
        bus.dout       = dout_q;
        bus.dout_valid = dout_valid_q;
        bus.word_start = word_start_q;
        bus.word_last  = active && (cnt_q == LastIdx);
        bus.load_ready = !hr_full_q;
        bus.busy       = active || hr_full_q;
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder: directed scenarios plus random
// traffic, scored against a queue of expected serial bits built from accepted words.
module tb_serial_word_feeder;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_word_feeder_if #(.WIDTH(W)) bus ();

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit   exp_q[$];     // expected serial bits, in output order
    bit   log_q[$];     // bits actually presented, per scenario
    int   pos = 0;      // position within the word of the next expected bit
    bit   hr_m = 1'b0;  // model of holding-register occupancy
    bit   last_new = 1'b0;
    logic prev_dout, prev_dv, prev_ws;

    function automatic bit word_bit(logic [W-1:0] w, int i);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        return w[i];
`else
        return w[W-1-i];
`endif
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos       = 0;
        hr_m      = 1'b0;
        prev_dout = 1'b0;
        prev_dv   = 1'b0;
        prev_ws   = 1'b0;
    endtask

    // One clock: sample what the DUT will see, advance, then score the result.
    task automatic step();
        bit           acc;
        bit           st;
        logic [W-1:0] d;
        bit           e;
        acc = bus.load_valid && bus.load_ready;
        st  = bus.stall;
        d   = bus.load_data;
        @(posedge clk);
        #1;
        last_new = 1'b0;
        if (st) begin
            check("hold_dout", bus.dout, prev_dout);
            check("hold_valid", bus.dout_valid, prev_dv);
            check("hold_start", bus.word_start, prev_ws);
        end else if (bus.dout_valid) begin
            last_new = 1'b1;
            log_q.push_back(bus.dout);
            check("bit_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dout", bus.dout, e);
                check("word_start", bus.word_start, pos == 0);
                check("word_last", bus.word_last, pos == W - 1);
                if (pos == 0) hr_m = 1'b0;
                pos = (pos + 1) % W;
            end
        end else begin
            check("gap", exp_q.size(), 0);
            check("idle_dout", bus.dout, 0);
            check("idle_start", bus.word_start, 0);
            check("idle_last", bus.word_last, 0);
        end
        if (acc) begin
            for (int i = 0; i < W; i++) exp_q.push_back(word_bit(d, i));
            hr_m = 1'b1;
        end
        check("load_ready", bus.load_ready, !hr_m);
        check("busy", bus.busy, bus.dout_valid || hr_m);
        prev_dout = bus.dout;
        prev_dv   = bus.dout_valid;
        prev_ws   = bus.word_start;
    endtask

    task automatic run_until_bits(int n, int max_cycles);
        int c;
        c = 0;
        while (log_q.size() < n && c < max_cycles) begin
            step();
            c++;
        end
        check("bit_timeout", log_q.size(), n);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_dout"}, bus.dout, 0);
        check({tag, "_valid"}, bus.dout_valid, 0);
        check({tag, "_start"}, bus.word_start, 0);
        check({tag, "_last"}, bus.word_last, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ready"}, bus.load_ready, 1);
    endtask

    function automatic logic [15:0] log_word(int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n && i < log_q.size(); i++) v = {v[14:0], log_q[i]};
        return v;
    endfunction

    logic [7:0] cap_d, cap_s, cap_l;

    initial begin
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.stall      = 1'b0;
        model_reset();

        // Power-on reset
        #1;
        check_reset_outputs("por");
        #11;
        rst = 1'b0;

        // Single word 8'h1D
        log_q.delete();
        bus.load_data  = 8'h1D;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        cap_d = '0; cap_s = '0; cap_l = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("single_valid", bus.dout_valid, 1);
            cap_d = {cap_d[6:0], bus.dout};
            cap_s = {cap_s[6:0], bus.word_start};
            cap_l = {cap_l[6:0], bus.word_last};
        end
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        check("single_bits", cap_d, 8'b10111000);
`else
        check("single_bits", cap_d, 8'b00011101);
`endif
        check("single_start", cap_s, 8'b10000000);
        check("single_last", cap_l, 8'b00000001);
        step();
        check("single_done_valid", bus.dout_valid, 0);
        check("single_done_busy", bus.busy, 0);

        // Back-to-back 8'h3C, 8'hC3
        log_q.delete();
        bus.load_data  = 8'h3C;
        bus.load_valid = 1'b1;
        step();
        bus.load_data  = 8'hC3;
        step();
        step();
        bus.load_valid = 1'b0;
        check("b2b_ready_low", bus.load_ready, 0);
        run_until_bits(16, 40);
        check("b2b_bits", log_word(16), 16'h3CC3);

        // Stall after bit 2 of 8'hA5; 8'h5A accepted during the stall
        repeat (3) step();
        log_q.delete();
        bus.load_data  = 8'hA5;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        run_until_bits(3, 10);
        bus.stall      = 1'b1;
        bus.load_data  = 8'h5A;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        check("stall_accept", bus.load_ready, 0);
        check("stall_dout", bus.dout, 1);
        step();
        step();
        bus.stall = 1'b0;
        run_until_bits(16, 40);
        check("stall_bits", log_word(16), 16'hA55A);
        repeat (2) step();

        // Reset during bit 4 of 8'hF0 with 8'h77 held
        log_q.delete();
        bus.load_data  = 8'hF0;
        bus.load_valid = 1'b1;
        step();
        bus.load_data  = 8'h77;
        run_until_bits(2, 10);
        bus.load_valid = 1'b0;
        check("held_word", bus.load_ready, 0);
        run_until_bits(5, 10);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        #2;
        rst = 1'b0;
        step();
        check("post_rst_idle", bus.dout_valid, 0);
        log_q.delete();
        bus.load_data  = 8'h81;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        run_until_bits(8, 12);
        check("post_rst_bits", log_word(8), 16'h0081);
        step();
        check("post_rst_done", bus.dout_valid, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.load_data  = W'($urandom);
            step();
        end
        bus.load_valid = 1'b0;
        bus.stall      = 1'b0;
        for (int i = 0; i < 24 && (exp_q.size() != 0 || bus.busy); i++) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-in, serial-out stage directly upstream of the serial sequence/palindrome detector FSMs.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on dout. dout connects to the detector's din.
- One holding register plus the shift register give gapless back-to-back words.
- Framing strobes (word_start, word_last) let downstream logic and benches align detector output to word boundaries.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit index counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately, independent of clk.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  holding register empty; a word is accepted on a posedge with load_valid and load_ready both high.
- stall  input  1  freezes the shifter when high.
- dout  output  1  serial bit; feeds the detector's din.
- dout_valid  output  1  dout carries a word bit.
- word_start  output  1  high while dout carries bit 0 of a word.
- word_last  output  1  high while dout carries bit WIDTH-1 of a word.
- busy  output  1  dout_valid OR holding register full.

Behaviour:
- Internal state:
  - hr / hr_full: holding register and its flag.
  - sr: shift register.
  - cnt: index of the bit currently on dout.
  - active: shifter busy.
- Reset values: dout=0, dout_valid=0, word_start=0, word_last=0, busy=0, load_ready=1, hr_full=0, active=0, cnt=0, sr=0, hr=0.
- All outputs are registered except load_ready=~hr_full, busy=active|hr_full, and word_last=active&(cnt==WIDTH-1). Each of these is a pure function of registered state.
- Accept: load_valid && !hr_full at posedge -> hr<=load_data, hr_full<=1. load_ready is not raised in the same cycle that hr empties; the next accept is possible one edge later.
- Shifter, when stall=0, on each posedge:
  - Case A, active && cnt<WIDTH-1: cnt<=cnt+1; dout<=next bit of sr; word_start<=0.
  - Case B, (!active || cnt==WIDTH-1) && hr_full: sr<=hr; hr_full<=0; cnt<=0; dout<=first bit of hr; dout_valid<=1; word_start<=1; active<=1.
  - Case C, (!active || cnt==WIDTH-1) && !hr_full: active<=0; dout_valid<=0; dout<=0; word_start<=0; cnt<=0.
- Bit order: MSB first by default.
- Latency: word accepted at edge N into an idle block -> bit 0 on dout after edge N+1 -> bit WIDTH-1 after edge N+WIDTH.
- Throughput: one bit per clock. When the next word is already in hr, no idle cycle occurs between words; its bit 0 follows the previous bit WIDTH-1 on the next edge.
- Stall:
  - While stall=1, sr, cnt, active, dout, dout_valid, word_start and hr->sr transfer all hold.
  - Accepts into hr still occur.
  - stall only freezes consumers that honour dout_valid; the detector samples din every clock and sees the held bit repeated.
- Simultaneous accept and transfer on the same edge is impossible, because load_ready=0 whenever hr_full=1.
- rst asserted mid-word: all state cleared asynchronously, and the partial word and any held word are discarded. After rst deasserts, the first accept is possible on the next posedge.
- load_data is ignored when load_valid=0 or load_ready=0.

Optional Feature:
- Macro: SERIAL_FEEDER_LSB_FIRST_EN.
- Defined: bits are shifted out LSB first. bit 0 on dout is load_data[0], and word_start/word_last keep their positional meaning (first and last bit shifted).
- Undefined: MSB first. bit 0 on dout is load_data[WIDTH-1].
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle -> outputs drop at once to dout=0, dout_valid=0, word_start=0, word_last=0, busy=0, load_ready=1.
- Single word: accept 8'h1D at edge N (idle, MSB build) -> dout=0,0,0,1,1,1,0,1 after edges N+1..N+8. word_start high only at N+1, word_last high only at N+8, dout_valid low after N+9.
- Back-to-back: 8'h3C then 8'hC3 offered continuously -> 16 contiguous valid bits 0011110011000011 with no gap. load_ready low from the second accept until the second word transfers to sr.
- Stall: 8'hA5 with stall=1 for 3 cycles after bit 2 -> dout holds 1 for 3 extra cycles, then bits 3..7 (0,0,1,0,1) resume. A word offered during the stall is accepted into hr.
- Reset mid-word: rst pulse during bit 4 of 8'hF0 with a second word held -> both words discarded. After release, a new 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- LSB build: accept 8'h1D -> dout=1,0,1,1,1,0,0,0, with word_start/word_last on the first and eighth bit.
